// File: rtl/tag_fill_ctrl_pkg.sv
// Shared tag-array geometry, block format and controller state encoding for tag_fill_ctrl.
package tag_fill_ctrl_pkg;

  localparam int NUM_ROWS    = 16;
  localparam int ADDR_WIDTH  = 4;
  localparam int NUM_BLOCKS  = 4;
  localparam int BLOCK_WIDTH = 8;
  localparam int ROW_WIDTH   = NUM_BLOCKS * BLOCK_WIDTH;
  localparam int VALID_BIT   = BLOCK_WIDTH - 1;
  localparam int WAY_WIDTH   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // A valid block carries the tag below the valid bit; fills replicate it into every lane.
  function automatic logic [ROW_WIDTH-1:0] fill_row(input logic [VALID_BIT-1:0] tag);
    return {NUM_BLOCKS{{1'b1, tag}}};
  endfunction

endpackage

// File: rtl/tag_fill_ctrl_way_rr.sv
// Per-row round-robin victim pointers: combinational read, increment on strobe, clear-all.
module way_rr_table
  import tag_fill_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WAY_WIDTH-1:0]  way,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] inc_addr,
  input  logic                  clear
);

  logic [WAY_WIDTH-1:0] ptr [NUM_ROWS];

  // Clear wins over increment so a flush always leaves every row starting at way 0.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NUM_ROWS; i++) ptr[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_ROWS; i++) ptr[i] <= '0;
    end else if (inc) begin
      ptr[inc_addr] <= ptr[inc_addr] + 1'b1;
    end
  end

  assign way = ptr[rd_addr];

endmodule

// File: rtl/tag_fill_ctrl.sv
// Tag-array write-side controller: round-robin fills and a sequenced full invalidate.
// Optional TAG_FILL_FLUSH_ON_RESET_EN: run a full flush automatically after reset.
module tag_fill_ctrl #(
  parameter int TAG_WIDTH  = 7,
  parameter int NUM_ROWS   = 16,
  parameter int NUM_BLOCKS = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_halt,
  input  logic                  i_miss_valid,
  input  logic [3:0]            i_miss_addr,
  input  logic [TAG_WIDTH-1:0]  i_miss_tag,
  output logic                  o_miss_ready,
  input  logic                  i_flush,
  output logic [3:0]            o_w_addr,
  output logic [31:0]           o_w_data,
  output logic [NUM_BLOCKS-1:0] o_w_wmask,
  output logic                  o_w_valid,
  output logic                  o_w_clk_en,
  output logic [1:0]            o_way,
  output logic                  o_done,
  output logic                  o_busy
);
  import tag_fill_ctrl_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_ROWS - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   row_q, row_d;
  logic                    w_valid_q, w_valid_d;
  logic [ADDR_WIDTH-1:0]   w_addr_q, w_addr_d;
  logic [ROW_WIDTH-1:0]    w_data_q, w_data_d;
  logic [NUM_BLOCKS-1:0]   w_wmask_q, w_wmask_d;
  logic [WAY_WIDTH-1:0]    way_q, way_d;
  logic                    done_q, done_d;
  logic [VALID_BIT-1:0]    tag_ext;
  logic [WAY_WIDTH-1:0]    rr_way;
  logic                    rr_inc, rr_clear;
  logic                    init_pending;

`ifdef TAG_FILL_FLUSH_ON_RESET_EN
  logic init_q;

  // Armed by reset, retired once the flush it requests is under way.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                 init_q <= 1'b1;
    else if (state_q == ST_FLUSH) init_q <= 1'b0;
  end

  assign init_pending = init_q;
`else
  assign init_pending = 1'b0;
`endif

  always_comb begin
    tag_ext = '0;
    tag_ext[TAG_WIDTH-1:0] = i_miss_tag;
  end

  assign o_miss_ready = (state_q == ST_IDLE) & ~i_halt & ~i_flush & ~init_pending;

  way_rr_table u_rr (
    .clk      (clk),
    .arst_n   (arst_n),
    .rd_addr  (i_miss_addr),
    .way      (rr_way),
    .inc      (rr_inc),
    .inc_addr (w_addr_q),
    .clear    (rr_clear)
  );

  // Write-port registers describe the write of the state being entered, so each
  // write appears the cycle after its decision; halt freezes every register.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    w_valid_d = w_valid_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    w_wmask_d = w_wmask_q;
    way_d     = way_q;
    done_d    = done_q;
    rr_inc    = 1'b0;
    rr_clear  = 1'b0;
    if (!i_halt) begin
      w_valid_d = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_flush || init_pending) begin
            state_d   = ST_FLUSH;
            row_d     = '0;
            w_valid_d = 1'b1;
            w_addr_d  = '0;
            w_data_d  = '0;
            w_wmask_d = '1;
            done_d    = (LAST_ROW == '0);
          end else if (i_miss_valid && o_miss_ready) begin
            state_d   = ST_FILL;
            w_valid_d = 1'b1;
            w_addr_d  = i_miss_addr;
            w_data_d  = fill_row(tag_ext);
            w_wmask_d = '0;
            w_wmask_d[rr_way] = 1'b1;
            way_d     = rr_way;
            done_d    = 1'b1;
          end
        end
        ST_FILL: begin
          rr_inc  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_FLUSH: begin
          rr_clear = 1'b1;
          if (row_q == LAST_ROW) begin
            state_d = ST_IDLE;
          end else begin
            row_d     = row_q + 1'b1;
            w_valid_d = 1'b1;
            w_addr_d  = row_q + 1'b1;
            w_data_d  = '0;
            w_wmask_d = '1;
            done_d    = ((row_q + 1'b1) == LAST_ROW);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      w_valid_q <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      w_wmask_q <= '0;
      way_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      w_valid_q <= w_valid_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      w_wmask_q <= w_wmask_d;
      way_q     <= way_d;
      done_q    <= done_d;
    end
  end

  assign o_w_valid  = w_valid_q & ~i_halt;
  assign o_w_clk_en = o_w_valid;
  assign o_done     = done_q & ~i_halt;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_w_addr   = w_addr_q;
  assign o_w_data   = w_data_q;
  assign o_w_wmask  = w_wmask_q;
  assign o_way      = way_q;

endmodule

// File: tb/tb_tag_fill_ctrl.sv
// Self-checking bench for tag_fill_ctrl: directed fill table, flush corner sequences,
// then randomized traffic against a transaction-level model of the tag writes.
module tb_tag_fill_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        i_halt;
  logic        i_miss_valid;
  logic [3:0]  i_miss_addr;
  logic [6:0]  i_miss_tag;
  logic        o_miss_ready;
  logic        i_flush;
  logic [3:0]  o_w_addr;
  logic [31:0] o_w_data;
  logic [3:0]  o_w_wmask;
  logic        o_w_valid;
  logic        o_w_clk_en;
  logic [1:0]  o_way;
  logic        o_done;
  logic        o_busy;

  typedef struct {
    bit          is_flush;
    logic [3:0]  addr;
    logic [6:0]  tag;
    logic [3:0]  exp_mask;
    logic [31:0] exp_data;
    logic [1:0]  exp_way;
  } vec_t;

  typedef struct {
    bit          is_fill;
    logic [3:0]  addr;
    logic [3:0]  mask;
    logic [31:0] data;
    bit          done;
    logic [1:0]  way;
  } wr_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t vecs[11];
  wr_t  exp_q[$];

  tag_fill_ctrl #(.TAG_WIDTH(7), .NUM_ROWS(16), .NUM_BLOCKS(4)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .i_halt       (i_halt),
    .i_miss_valid (i_miss_valid),
    .i_miss_addr  (i_miss_addr),
    .i_miss_tag   (i_miss_tag),
    .o_miss_ready (o_miss_ready),
    .i_flush      (i_flush),
    .o_w_addr     (o_w_addr),
    .o_w_data     (o_w_data),
    .o_w_wmask    (o_w_wmask),
    .o_w_valid    (o_w_valid),
    .o_w_clk_en   (o_w_clk_en),
    .o_way        (o_way),
    .o_done       (o_done),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // A valid block is {1, tag}; the fill row is that byte in all four lanes.
  function automatic logic [31:0] model_row(input logic [6:0] tag);
    logic [7:0] blk;
    blk = 8'h80 | {1'b0, tag};
    return blk * 32'h0101_0101;
  endfunction

  task automatic check_all_zero(input string tag);
    check_output({tag, "_valid"}, o_w_valid, 0);
    check_output({tag, "_clk_en"}, o_w_clk_en, 0);
    check_output({tag, "_done"}, o_done, 0);
    check_output({tag, "_busy"}, o_busy, 0);
    check_output({tag, "_addr"}, o_w_addr, 0);
    check_output({tag, "_data"}, o_w_data, 0);
    check_output({tag, "_wmask"}, o_w_wmask, 0);
    check_output({tag, "_way"}, o_way, 0);
  endtask

  task automatic wait_ready();
    bit ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (o_miss_ready && !o_busy) ok = 1;
    end
    check_output("ready_after_reset", ok, 1);
  endtask

  task automatic reset_dut();
    i_halt = 0; i_flush = 0; i_miss_valid = 0; i_miss_addr = 0; i_miss_tag = 0;
    arst_n = 0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    arst_n = 1;
    wait_ready();
  endtask

  task automatic apply_stimulus_fill(input int idx, input vec_t v);
    @(negedge clk);
    i_miss_valid = 1; i_miss_addr = v.addr; i_miss_tag = v.tag;
    #1;
    check_output($sformatf("fill%0d_ready", idx), o_miss_ready, 1);
    @(negedge clk);
    i_miss_valid = 0;
    check_output($sformatf("fill%0d_valid", idx), o_w_valid, 1);
    check_output($sformatf("fill%0d_addr", idx), o_w_addr, v.addr);
    check_output($sformatf("fill%0d_mask", idx), o_w_wmask, v.exp_mask);
    check_output($sformatf("fill%0d_data", idx), o_w_data, v.exp_data);
    check_output($sformatf("fill%0d_way", idx), o_way, v.exp_way);
    check_output($sformatf("fill%0d_done", idx), o_done, 1);
    check_output($sformatf("fill%0d_busy", idx), o_busy, 1);
  endtask

  // Flush from IDLE, optionally halting at one row or resetting at one row.
  task automatic run_flush(input int halt_row, input int halt_len, input int reset_row);
    int  r = 0;
    int  halted = 0;
    bit  was_reset = 0;
    @(negedge clk);
    i_flush = 1;
    #1;
    check_output("flush_req_ready", o_miss_ready, 0);
    check_output("flush_req_busy", o_busy, 0);
    @(negedge clk);
    i_flush = 0;
    for (int guard = 0; guard < 64 && r < 16 && !was_reset; guard++) begin
      if (r == reset_row) begin
        arst_n = 0;
        #1;
        check_all_zero("rst_mid_flush");
        was_reset = 1;
      end else if (r == halt_row && halted < halt_len) begin
        i_halt = 1;
        #1;
        check_output($sformatf("halt%0d_valid", halted), o_w_valid, 0);
        check_output($sformatf("halt%0d_clk_en", halted), o_w_clk_en, 0);
        check_output($sformatf("halt%0d_busy", halted), o_busy, 1);
        halted++;
        @(negedge clk);
      end else begin
        i_halt = 0;
        #1;
        check_output($sformatf("flush_r%0d_valid", r), o_w_valid, 1);
        check_output($sformatf("flush_r%0d_clk_en", r), o_w_clk_en, 1);
        check_output($sformatf("flush_r%0d_addr", r), o_w_addr, r);
        check_output($sformatf("flush_r%0d_mask", r), o_w_wmask, 4'hF);
        check_output($sformatf("flush_r%0d_data", r), o_w_data, 0);
        check_output($sformatf("flush_r%0d_done", r), o_done, (r == 15));
        check_output($sformatf("flush_r%0d_busy", r), o_busy, 1);
        r++;
        @(negedge clk);
      end
    end
    if (!was_reset) begin
      check_output("flush_rows_written", r, 16);
      check_output("flush_end_busy", o_busy, 0);
      check_output("flush_end_valid", o_w_valid, 0);
      check_output("flush_end_ready", o_miss_ready, 1);
    end
  endtask

  initial begin
    vecs[0]  = '{0, 4'd3, 7'h2A, 4'b0001, 32'hAAAA_AAAA, 2'd0};
    vecs[1]  = '{0, 4'd3, 7'h2A, 4'b0010, 32'hAAAA_AAAA, 2'd1};
    vecs[2]  = '{0, 4'd3, 7'h2A, 4'b0100, 32'hAAAA_AAAA, 2'd2};
    vecs[3]  = '{0, 4'd3, 7'h2A, 4'b1000, 32'hAAAA_AAAA, 2'd3};
    vecs[4]  = '{0, 4'd3, 7'h2A, 4'b0001, 32'hAAAA_AAAA, 2'd0};
    vecs[5]  = '{0, 4'd5, 7'h05, 4'b0001, 32'h8585_8585, 2'd0};
    vecs[6]  = '{0, 4'd6, 7'h7F, 4'b0001, 32'hFFFF_FFFF, 2'd0};
    vecs[7]  = '{1, 4'd0, 7'h00, 4'b0000, 32'h0,         2'd0};
    vecs[8]  = '{0, 4'd5, 7'h00, 4'b0001, 32'h8080_8080, 2'd0};
    vecs[9]  = '{0, 4'd3, 7'h2A, 4'b0001, 32'hAAAA_AAAA, 2'd0};
    vecs[10] = '{0, 4'd3, 7'h11, 4'b0010, 32'h9191_9191, 2'd1};

    reset_dut();

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_flush) run_flush(-1, 0, -1);
      else                  apply_stimulus_fill(i, vecs[i]);
    end

    // Flush and miss in the same cycle; the held miss is taken right after the flush.
    @(negedge clk);
    i_flush = 1; i_miss_valid = 1; i_miss_addr = 4'd2; i_miss_tag = 7'h11;
    #1;
    check_output("fm_ready_low", o_miss_ready, 0);
    @(negedge clk);
    i_flush = 0;
    for (int r = 0; r < 16; r++) begin
      check_output($sformatf("fm_r%0d_ready", r), o_miss_ready, 0);
      check_output($sformatf("fm_r%0d_addr", r), o_w_addr, r);
      check_output($sformatf("fm_r%0d_valid", r), o_w_valid, 1);
      @(negedge clk);
    end
    check_output("fm_idle_ready", o_miss_ready, 1);
    check_output("fm_idle_valid", o_w_valid, 0);
    @(negedge clk);
    i_miss_valid = 0;
    check_output("fm_fill_valid", o_w_valid, 1);
    check_output("fm_fill_addr", o_w_addr, 2);
    check_output("fm_fill_mask", o_w_wmask, 4'b0001);
    check_output("fm_fill_data", o_w_data, 32'h9191_9191);
    check_output("fm_fill_done", o_done, 1);

    run_flush(7, 3, -1);

    run_flush(-1, 0, 9);
    @(negedge clk);
    check_output("rst_hold_valid", o_w_valid, 0);
    check_output("rst_hold_busy", o_busy, 0);
    arst_n = 1;
`ifdef TAG_FILL_FLUSH_ON_RESET_EN
    @(negedge clk);
    check_output("rst_restart_valid", o_w_valid, 1);
    check_output("rst_restart_addr", o_w_addr, 0);
    check_output("rst_restart_ready", o_miss_ready, 0);
    wait_ready();
`else
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output($sformatf("rst_idle%0d_busy", k), o_busy, 0);
      check_output($sformatf("rst_idle%0d_valid", k), o_w_valid, 0);
      check_output($sformatf("rst_idle%0d_ready", k), o_miss_ready, 1);
    end
`endif

    // Randomized traffic: each accepted request expands into its expected writes.
    reset_dut();
    begin
      int         cnt[16];
      logic [1:0] model_way = 0;
      bit         popped;
      bit         fl, v;
      logic [3:0] a;
      logic [6:0] t;
      wr_t        e;
      for (int i = 0; i < 16; i++) cnt[i] = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        @(negedge clk);
        popped = 0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          popped = 1;
          if (e.is_fill) model_way = e.way;
          check_output("rnd_valid", o_w_valid, 1);
          check_output("rnd_addr", o_w_addr, e.addr);
          check_output("rnd_mask", o_w_wmask, e.mask);
          check_output("rnd_data", o_w_data, e.data);
          check_output("rnd_done", o_done, e.done);
        end else begin
          check_output("rnd_idle_valid", o_w_valid, 0);
          check_output("rnd_idle_done", o_done, 0);
        end
        check_output("rnd_busy", o_busy, popped);
        check_output("rnd_way", o_way, model_way);
        fl = ($urandom_range(0, 29) == 0);
        v  = $urandom_range(0, 1) == 1;
        a  = 4'($urandom_range(0, 3));
        t  = 7'($urandom_range(0, 127));
        i_flush = fl; i_miss_valid = v; i_miss_addr = a; i_miss_tag = t;
        #1;
        check_output("rnd_ready", o_miss_ready, (!popped && !fl));
        if (!popped) begin
          if (fl) begin
            for (int r = 0; r < 16; r++) exp_q.push_back('{0, 4'(r), 4'hF, 32'h0, (r == 15), 2'd0});
            for (int i = 0; i < 16; i++) cnt[i] = 0;
          end else if (v) begin
            exp_q.push_back('{1, a, 4'(1 << cnt[a]), model_row(t), 1, 2'(cnt[a])});
            cnt[a] = (cnt[a] + 1) % 4;
          end
        end
      end
      i_flush = 0; i_miss_valid = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
